qaddsub_pipe: RTL and testbench

- Pipelined, parameterised sign-magnitude fixed-point adder/subtractor with valid/ready handshakes on input and output.
- Successor to the team's combinational Q-format adder. Adds:
  - a per-operation add/subtract select
  - overflow detection with selectable saturate or wrap
  - negative-zero normalisation
  - a two-stage registered pipeline that tolerates downstream backpressure
- Sits between operand producers (register file, DSP datapath) and consumers such as the multiplier/divider stages.

---
 rtl/qfix_pkg.sv | 13 +
 rtl/qaddsub_core.sv | 20 ++
 rtl/qaddsub_pipe.sv | 71 +++++++
 tb/tb_qaddsub_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qfix_pkg.sv
// qfix_pkg: sign-magnitude field helpers and constants shared by the Q-format arithmetic blocks.
package qfix_pkg;
    localparam int NMAX = 64;
    localparam logic [NMAX-1:0] SAT_MAG = '1;

    function automatic logic sign_of(input logic [NMAX-1:0] x, input int n);
        return x[n-1];
    endfunction

    function automatic logic [NMAX-1:0] mag_of(input logic [NMAX-1:0] x, input int n);
        return x & ~({NMAX{1'b1}} << (n - 1));
    endfunction
endpackage

// File: rtl/qaddsub_core.sv
// qaddsub_core: combinational sign-magnitude add of two signed magnitudes, carry kept in raw[N-1].
module qaddsub_core #(
    parameter int N = 32
) (
    input  logic         sa,
    input  logic [N-2:0] ma,
    input  logic         sb,
    input  logic [N-2:0] mb,
    output logic         s,
    output logic [N-1:0] raw
);
    logic same, ge;

    always_comb begin
        same = sa == sb;
        ge   = ma >= mb;
        raw  = same ? {1'b0, ma} + {1'b0, mb} : ge ? {1'b0, ma - mb} : {1'b0, mb - ma};
        s    = same || ge ? sa : sb;
    end
endmodule

// File: rtl/qaddsub_pipe.sv
// qaddsub_pipe: two-stage valid/ready sign-magnitude adder/subtractor with overflow saturate or wrap.
module qaddsub_pipe
    import qfix_pkg::*;
#(
    parameter int N   = 32,
    parameter int Q   = 15,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);
    localparam bit CFG_OK = Q < N - 1 && N >= 4 && N <= 64;

    logic         s1_valid, s2_valid, s1_sign, r_sign, adv1, adv2;
    logic [N-1:0] s1_raw, r_raw;
    logic [N-2:0] fin_mag;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    qaddsub_core #(.N(N)) u_core (
        .sa  (sign_of(64'(a), N)),
        .ma  ((N-1)'(mag_of(64'(a), N))),
        .sb  (sign_of(64'(b), N) ^ sub),
        .mb  ((N-1)'(mag_of(64'(b), N))),
        .s   (r_sign),
        .raw (r_raw)
    );

    // carry out only arises on a same-sign add; sign survives, zero magnitude is always +0
    assign fin_mag = s1_raw[N-1] && SAT != 0 ? (N-1)'(SAT_MAG) : s1_raw[N-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_raw   <= '0;
            s2_valid <= 1'b0;
            c        <= '0;
            ovf      <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= r_sign;
                    s1_raw  <= r_raw;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    c   <= {s1_sign && |fin_mag, fin_mag};
                    ovf <= s1_raw[N-1];
                end
            end
        end
    end

    always_ff @(posedge clk) assert (CFG_OK);
endmodule

// File: tb/tb_qaddsub_pipe.sv
// tb_qaddsub_pipe: directed and streaming checks of qaddsub_pipe with SAT=1 and SAT=0 instances in lockstep.
module tb_qaddsub_pipe;
    logic        clk = 0, rst_n = 0, in_valid = 0, sub = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, ovf, in_ready0, out_valid0, ovf0;
    logic [31:0] c, c0;
    int          checks = 0, errors = 0;

    qaddsub_pipe #(.N(32), .Q(15), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
    );
    qaddsub_pipe #(.N(32), .Q(15), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
        .sub(sub), .out_valid(out_valid0), .out_ready(out_ready), .c(c0), .ovf(ovf0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // reference via signed integer arithmetic; returns {ovf, c}
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic s, input bit sat);
        longint va = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
        longint vb = (y[31] ^ s) ? -longint'(y[30:0]) : longint'(y[30:0]);
        longint r  = va + vb;
        longint m  = r < 0 ? -r : r;
        logic   o  = m > 64'h7FFF_FFFF;
        logic [30:0] mg = (o && sat) ? 31'h7FFF_FFFF : m[30:0];
        return {o, (mg != 0) && (r < 0), mg};
    endfunction

    task automatic send_wait(input logic [31:0] x, input logic [31:0] y, input logic s, output int lat);
        @(negedge clk);
        a = x; b = y; sub = s; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c got %h exp 0", c); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic_add;
        int lat;
        send_wait(32'h0000_FFFF, 32'h0000_0001, 1'b0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", lat); end
        checks++; if (c !== 32'h0001_0000) begin errors++; $display("FAIL basic_c got %h exp 00010000", c); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_sub_zero;
        logic [31:0] va[4] = '{32'h0000_0005, 32'h8000_0005, 32'h0000_0001, 32'h8000_0000};
        logic [31:0] vb[4] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_8000, 32'h8000_0000};
        logic        vs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ve[4] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_7FFF, 32'h0000_0000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_wait(va[i], vb[i], vs[i], lat);
            checks++; if (lat !== 2) begin errors++; $display("FAIL subzero_latency[%0d] got %0d exp 2", i, lat); end
            checks++; if (c !== ve[i]) begin errors++; $display("FAIL subzero_c[%0d] got %h exp %h", i, c, ve[i]); end
            checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL subzero_ovf[%0d] got %b exp 0", i, ovf); end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] vx[2] = '{32'h7FFF_FFFF, 32'hC000_0000};
        logic [31:0] e1[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e0[2] = '{32'h7FFF_FFFE, 32'h0000_0000};
        int lat;
        for (int i = 0; i < 2; i++) begin
            send_wait(vx[i], vx[i], 1'b0, lat);
            checks++; if (c !== e1[i]) begin errors++; $display("FAIL ovf_sat_c[%0d] got %h exp %h", i, c, e1[i]); end
            checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag[%0d] got %b exp 1", i, ovf); end
            checks++; if (c0 !== e0[i]) begin errors++; $display("FAIL ovf_wrap_c[%0d] got %h exp %h", i, c0, e0[i]); end
            checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag[%0d] got %b exp 1", i, ovf0); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] vals[4] = '{32'd1, 32'd2, 32'd3, 32'd4};
        logic [31:0] got[$];
        int idx = 0, cyc = 0;
        @(negedge clk);
        out_ready = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1; a = vals[idx]; b = vals[idx]; sub = 0;
            #1;
            if (in_ready) idx++;
            @(negedge clk);
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || c !== 32'd2) begin errors++; $display("FAIL bp_hold[%0d] got v=%b c=%h exp v=1 c=00000002", k, out_valid, c); end
            @(negedge clk);
        end
        while (got.size() < 4 && cyc < 20) begin
            out_ready = 1;
            in_valid = idx < 4;
            if (idx < 4) begin a = vals[idx]; b = vals[idx]; end
            #1;
            if (out_valid) got.push_back(c);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 0;
        checks++; if (cyc !== 4) begin errors++; $display("FAIL bp_drain_cycles got %0d exp 4", cyc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= got.size() || got[k] !== 2 * vals[k]) begin
                errors++;
                $display("FAIL bp_result[%0d] got %h exp %h", k, k < got.size() ? got[k] : 32'hx, 2 * vals[k]);
            end
        end
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
    endtask

    task automatic test_stream;
        logic [32:0] q1[$], q0[$];
        logic [32:0] e;
        logic [31:0] x, y;
        int sent = 0, recv = 0, cyc = 0;
        while (recv < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = $urandom_range(0, 3) != 0;
            in_valid  = sent < 100 && $urandom_range(0, 3) != 0;
            case ($urandom_range(0, 3))
                0: begin x = $urandom; y = $urandom; end
                1: begin x = {1'($urandom), 27'd0, 4'($urandom)}; y = {1'($urandom), 27'd0, 4'($urandom)}; end
                2: begin x = {1'($urandom), 23'h7FFFFF, 8'($urandom)}; y = {1'($urandom), 23'h7FFFFF, 8'($urandom)}; end
                default: begin x = $urandom; y = {1'($urandom), x[30:0]}; end
            endcase
            a = x; b = y; sub = 1'($urandom);
            #1;
            checks++;
            if (in_ready0 !== in_ready || out_valid0 !== out_valid) begin
                errors++;
                $display("FAIL stream_lockstep got rdy0=%b v0=%b exp rdy=%b v=%b", in_ready0, out_valid0, in_ready, out_valid);
            end
            if (out_valid && out_ready) begin
                recv++;
                e = q1.size() ? q1.pop_front() : 33'hx;
                checks++; if ({ovf, c} !== e) begin errors++; $display("FAIL stream_sat[%0d] got ovf=%b c=%h exp ovf=%b c=%h", recv, ovf, c, e[32], e[31:0]); end
                e = q0.size() ? q0.pop_front() : 33'hx;
                checks++; if ({ovf0, c0} !== e) begin errors++; $display("FAIL stream_wrap[%0d] got ovf=%b c=%h exp ovf=%b c=%h", recv, ovf0, c0, e[32], e[31:0]); end
            end
            if (in_valid && in_ready) begin
                q1.push_back(model(a, b, sub, 1'b1));
                q0.push_back(model(a, b, sub, 1'b0));
                sent++;
            end
        end
        in_valid = 0;
        checks++; if (recv !== 100) begin errors++; $display("FAIL stream_count got %0d exp 100", recv); end
    endtask

    task automatic test_reset_mid;
        int lat, stale = 0;
        @(negedge clk);
        out_ready = 1; in_valid = 1; a = 32'd10; b = 32'd20; sub = 0;
        @(negedge clk);
        a = 32'd30; b = 32'd40;
        @(posedge clk);
        #3;
        rst_n = 0;
        in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
        checks++; if (c !== 32'h0) begin errors++; $display("FAIL rstmid_c got %h exp 0", c); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b exp 0", ovf); end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale got %0d exp 0", stale); end
        send_wait(32'd3, 32'd4, 1'b0, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_latency got %0d exp 2", lat); end
        checks++; if (c !== 32'd7) begin errors++; $display("FAIL rstmid_c_after got %h exp 00000007", c); end
    endtask

    initial begin
        test_reset;
        test_basic_add;
        test_sub_zero;
        test_overflow;
        test_backpressure;
        test_stream;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
